// File: rtl/cache_pkg.sv
// Shared definitions for the cache controller and its request arbiter:
// address geometry and the arbiter state encoding.
package cache_pkg;

    localparam int ADDR_W   = 32;
    localparam int INDEX_W  = 7;
    localparam int TAG_W    = 19;
    localparam int OFFSET_W = ADDR_W - INDEX_W - TAG_W;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Tag field of a cache address (upper TAG_W bits).
    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    // Set index field of a cache address (bits just above the line offset).
    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker: chooses the first set request bit searching
// upward from last+1 and wrapping to 0. Purely combinational.
module rr_priority_picker #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req_vec,
    input  logic [1:0]         last,
    output logic [NUM_REQ-1:0] grant,
    output logic [1:0]         grant_idx
);

    logic [NUM_REQ-1:0] grant_s;
    logic [1:0]         grant_idx_s;
    logic               found_s;
    logic               take_s;

    // Two-pass search: indices above last first, then wrap to 0..last.
    always_comb begin
        grant_s     = '0;
        grant_idx_s = 2'd0;
        found_s     = 1'b0;
        take_s      = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            take_s      = req_vec[i] & (i > int'(last)) & ~found_s;
            grant_s[i]  = grant_s[i] | take_s;
            grant_idx_s = grant_idx_s | ({2{take_s}} & 2'(i));
            found_s     = found_s | take_s;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            take_s      = req_vec[i] & (i <= int'(last)) & ~found_s;
            grant_s[i]  = grant_s[i] | take_s;
            grant_idx_s = grant_idx_s | ({2{take_s}} & 2'(i));
            found_s     = found_s | take_s;
        end
    end

    assign grant     = grant_s;
    assign grant_idx = grant_idx_s;

endmodule

// File: rtl/cache_req_arbiter.sv
// Arbiter sharing the cache controller request port between NUM_REQ
// requesters. Round-robin grant in IDLE, latched access held in BUSY until
// cache_ready or the watchdog expires, then a one-cycle done to the winner.
module cache_req_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = cache_pkg::ADDR_W,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        done,
    output logic [ADDR_W-1:0]         cache_addr,
    output logic                      cache_read,
    output logic                      cache_write,
    input  logic                      cache_ready,
    output logic                      busy,
    output logic [1:0]                grant_id,
    output logic                      timeout_err
);

    import cache_pkg::*;

    localparam logic [1:0] LAST_RST = 2'(NUM_REQ - 1);
    localparam logic [7:0] WAIT_MAX = 8'(TIMEOUT - 1);

    arb_state_t         state_r;
    arb_state_t         state_nx_s;
    logic [NUM_REQ-1:0] pick_onehot_s;
    logic [1:0]         pick_idx_s;
    logic               any_req_s;
    logic [ADDR_W-1:0]  addr_sel_s;
    logic               write_sel_s;
    logic [NUM_REQ-1:0] done_nx_s;
    logic [NUM_REQ-1:0] req_ready_s;
    logic               busy_s;
    logic               wait_exp_s;
    logic               finish_s;

    logic [1:0]         last_r;
    logic [1:0]         grant_id_r;
    logic [ADDR_W-1:0]  cache_addr_r;
    logic               cache_read_r;
    logic               cache_write_r;
    logic [NUM_REQ-1:0] done_r;
    logic [7:0]         wait_cnt_r;
    logic               timeout_err_r;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_vec   (req_valid),
        .last      (last_r),
        .grant     (pick_onehot_s),
        .grant_idx (pick_idx_s)
    );

    assign any_req_s  = |req_valid;
    assign wait_exp_s = (wait_cnt_r == WAIT_MAX);
    assign finish_s   = cache_ready | wait_exp_s;

    // One-hot AND-OR mux of the winner's address/direction and the done vector.
    always_comb begin
        addr_sel_s  = '0;
        write_sel_s = 1'b0;
        done_nx_s   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_sel_s   = addr_sel_s | ({ADDR_W{pick_onehot_s[i]}} & req_addr[i*ADDR_W +: ADDR_W]);
            write_sel_s  = write_sel_s | (pick_onehot_s[i] & req_write[i]);
            done_nx_s[i] = (grant_id_r == 2'(i));
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state: grant when any request is pending, leave BUSY on completion or watchdog.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (any_req_s) begin
                    state_nx_s = ARB_BUSY;
                end else begin
                    state_nx_s = ARB_IDLE;
                end
            end
            ARB_BUSY: begin
                if (finish_s) begin
                    state_nx_s = ARB_IDLE;
                end else begin
                    state_nx_s = ARB_BUSY;
                end
            end
            default: state_nx_s = ARB_IDLE;
        endcase
    end

    // FSM outputs: accept pulse only while IDLE, busy flag while BUSY.
    always_comb begin
        req_ready_s = '0;
        busy_s      = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                req_ready_s = pick_onehot_s;
                busy_s      = 1'b0;
            end
            ARB_BUSY: begin
                req_ready_s = '0;
                busy_s      = 1'b1;
            end
            default: begin
                req_ready_s = '0;
                busy_s      = 1'b0;
            end
        endcase
    end

    // Access latches, registered strobes, done pulse, watchdog and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r        <= LAST_RST;
            grant_id_r    <= LAST_RST;
            cache_addr_r  <= '0;
            cache_read_r  <= 1'b0;
            cache_write_r <= 1'b0;
            done_r        <= '0;
            wait_cnt_r    <= 8'd0;
            timeout_err_r <= 1'b0;
        end else begin
            done_r <= '0;
            case (state_r)
                ARB_IDLE: begin
                    wait_cnt_r <= 8'd0;
                    if (any_req_s) begin
                        cache_addr_r  <= addr_sel_s;
                        cache_read_r  <= ~write_sel_s;
                        cache_write_r <= write_sel_s;
                        last_r        <= pick_idx_s;
                        grant_id_r    <= pick_idx_s;
                    end else begin
                        cache_read_r  <= 1'b0;
                        cache_write_r <= 1'b0;
                    end
                end
                ARB_BUSY: begin
                    if (finish_s) begin
                        cache_read_r  <= 1'b0;
                        cache_write_r <= 1'b0;
                        done_r        <= done_nx_s;
                        wait_cnt_r    <= 8'd0;
                        // A completion that coincides with expiry is a normal completion.
                        timeout_err_r <= timeout_err_r | ~cache_ready;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                default: begin
                    cache_read_r  <= 1'b0;
                    cache_write_r <= 1'b0;
                    wait_cnt_r    <= 8'd0;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_s;
    assign done        = done_r;
    assign cache_addr  = cache_addr_r;
    assign cache_read  = cache_read_r;
    assign cache_write = cache_write_r;
    assign busy        = busy_s;
    assign grant_id    = grant_id_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed self-checking bench for cache_req_arbiter with three requesters
// and an 8-cycle watchdog.
module tb_cache_req_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 32;

    logic            clk;
    logic            rst;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0] req_ready;
    logic [NREQ-1:0] done;
    logic [AW-1:0]   cache_addr;
    logic            cache_read;
    logic            cache_write;
    logic            cache_ready;
    logic            busy;
    logic [1:0]      grant_id;
    logic            timeout_err;

    int n_cmp;
    int n_err;
    logic [NREQ-1:0] exp_oh;

    cache_req_arbiter #(
        .NUM_REQ (NREQ),
        .ADDR_W  (AW),
        .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .done        (done),
        .cache_addr  (cache_addr),
        .cache_read  (cache_read),
        .cache_write (cache_write),
        .cache_ready (cache_ready),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst         = 1'b1;
        req_valid   = 3'b000;
        req_write   = 3'b000;
        req_addr    = '0;
        cache_ready = 1'b0;
        exp_oh      = 3'b000;

        // Reset state
        tick();
        tick();
        chk("rst_busy",      32'(busy),        32'd0);
        chk("rst_grant_id",  32'(grant_id),    32'd2);
        chk("rst_addr",      32'(cache_addr),  32'd0);
        chk("rst_read",      32'(cache_read),  32'd0);
        chk("rst_write",     32'(cache_write), 32'd0);
        chk("rst_req_ready", 32'(req_ready),   32'd0);
        chk("rst_done",      32'(done),        32'd0);
        chk("rst_tmo_err",   32'(timeout_err), 32'd0);
        rst = 1'b0;

        // Requester 0 reads 0x0000_1080, completion at cycle 3
        req_addr[31:0] = 32'h0000_1080;
        req_valid      = 3'b001;
        #1;
        chk("t1_req_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 3'b000;
        #1;
        chk("t1_read",      32'(cache_read),  32'd1);
        chk("t1_write",     32'(cache_write), 32'd0);
        chk("t1_addr",      32'(cache_addr),  32'h0000_1080);
        chk("t1_busy",      32'(busy),        32'd1);
        chk("t1_grant_id",  32'(grant_id),    32'd0);
        chk("t1_rdy_busy",  32'(req_ready),   32'd0);
        tick();
        tick();
        cache_ready = 1'b1;
        chk("t1_read_hold", 32'(cache_read), 32'd1);
        tick();
        cache_ready = 1'b0;
        chk("t1_done",      32'(done),       32'h1);
        chk("t1_read_off",  32'(cache_read), 32'd0);
        chk("t1_busy_off",  32'(busy),       32'd0);
        tick();
        chk("t1_done_once", 32'(done), 32'd0);

        // cache_ready while IDLE is ignored
        cache_ready = 1'b1;
        tick();
        cache_ready = 1'b0;
        chk("idle_rdy_done", 32'(done), 32'd0);
        chk("idle_rdy_busy", 32'(busy), 32'd0);

        // Requester 1 writes 0x0000_2000, then drops valid and changes address
        req_addr[63:32] = 32'h0000_2000;
        req_write       = 3'b010;
        req_valid       = 3'b010;
        #1;
        chk("t2_req_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid       = 3'b000;
        req_addr[63:32] = 32'hDEAD_BEEF;
        chk("t2_addr",     32'(cache_addr),  32'h0000_2000);
        chk("t2_write",    32'(cache_write), 32'd1);
        chk("t2_read",     32'(cache_read),  32'd0);
        chk("t2_grant_id", 32'(grant_id),    32'd1);
        tick();
        chk("t2_addr_hold",  32'(cache_addr),  32'h0000_2000);
        chk("t2_write_hold", 32'(cache_write), 32'd1);
        tick();
        cache_ready = 1'b1;
        chk("t2_write_hold2", 32'(cache_write), 32'd1);
        tick();
        cache_ready = 1'b0;
        req_write   = 3'b000;
        chk("t2_done",      32'(done),        32'h2);
        chk("t2_write_off", 32'(cache_write), 32'd0);

        // Watchdog: requester 0 read never completed, 8 BUSY cycles then abort
        req_addr[31:0] = 32'h0000_4000;
        req_valid      = 3'b001;
        #1;
        chk("to_req_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 3'b000;
        chk("to_err_pre", 32'(timeout_err), 32'd0);
        for (int k = 0; k < 8; k++) begin
            chk("to_read_held", 32'(cache_read), 32'd1);
            tick();
        end
        chk("to_read_off", 32'(cache_read),  32'd0);
        chk("to_done",     32'(done),        32'h1);
        chk("to_err",      32'(timeout_err), 32'd1);

        // Sticky error survives a later normal access
        req_addr[63:32] = 32'h0000_5000;
        req_valid       = 3'b010;
        #1;
        chk("to2_req_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid   = 3'b000;
        cache_ready = 1'b1;
        chk("to2_err_hold", 32'(timeout_err), 32'd1);
        tick();
        cache_ready = 1'b0;
        chk("to2_done",      32'(done),        32'h2);
        chk("to2_err_hold2", 32'(timeout_err), 32'd1);

        // Reset during BUSY abandons the access and clears the error
        req_addr[95:64] = 32'h0000_3000;
        req_valid       = 3'b100;
        #1;
        chk("rs_req_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = 3'b000;
        chk("rs_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        chk("rs_busy",     32'(busy),        32'd0);
        chk("rs_read",     32'(cache_read),  32'd0);
        chk("rs_addr",     32'(cache_addr),  32'd0);
        chk("rs_done",     32'(done),        32'd0);
        chk("rs_grant_id", 32'(grant_id),    32'd2);
        chk("rs_tmo_err",  32'(timeout_err), 32'd0);
        rst = 1'b0;
        tick();
        chk("rs_no_done", 32'(done), 32'd0);

        // Fairness: all valid, cache_ready two cycles after each strobe
        req_addr[31:0]  = 32'h0000_0100;
        req_addr[63:32] = 32'h0000_0200;
        req_addr[95:64] = 32'h0000_0300;
        req_write       = 3'b000;
        req_valid       = 3'b111;
        for (int j = 0; j < 6; j++) begin
            int e;
            e      = j % 3;
            exp_oh = 3'(1 << e);
            #1;
            chk("rr_req_ready", 32'(req_ready), 32'(exp_oh));
            tick();
            chk("rr_grant_id", 32'(grant_id),   32'(e));
            chk("rr_addr",     32'(cache_addr), 32'(256 * (e + 1)));
            tick();
            tick();
            cache_ready = 1'b1;
            tick();
            cache_ready = 1'b0;
            if (j == 5) begin
                req_valid = 3'b000;
            end
            chk("rr_done", 32'(done), 32'(exp_oh));
        end

        // Back-to-back: requester 0 asserts valid in the done cycle of requester 1
        req_addr[63:32] = 32'h0000_6000;
        req_valid       = 3'b010;
        #1;
        chk("bb_req_ready1", 32'(req_ready), 32'h2);
        tick();
        req_valid   = 3'b000;
        cache_ready = 1'b1;
        tick();
        cache_ready    = 1'b0;
        req_addr[31:0] = 32'h0000_7000;
        req_valid      = 3'b001;
        #1;
        chk("bb_done1",      32'(done),      32'h2);
        chk("bb_req_ready0", 32'(req_ready), 32'h1);
        tick();
        req_valid = 3'b000;
        chk("bb_busy",     32'(busy),       32'd1);
        chk("bb_grant_id", 32'(grant_id),   32'd0);
        chk("bb_addr",     32'(cache_addr), 32'h0000_7000);
        cache_ready = 1'b1;
        tick();
        cache_ready = 1'b0;
        chk("bb_done0", 32'(done), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_req_arbiter.md
# cache_req_arbiter

Shares the single request port of `cache_controller` between `NUM_REQ` requesters, for example instruction fetch, data load/store and DMA snoop. Each cycle in which the cache is free, the block picks one pending requester by round-robin and latches its address and direction. It drives `read`/`write` toward the controller until `ready` completes the access, then returns a one-cycle `done` to the winner. A watchdog aborts any access that the controller never completes.

## Interface
- `NUM_REQ`, 2: number of requesters, legal range 2..4.
- `ADDR_W`, 32: address width, matching the cache controller.
- `TIMEOUT`, 64: maximum cycles to wait in BUSY for `cache_ready`, legal range 2..255.
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  NUM_REQ: requester i has a pending access.
- `req_write`  in  NUM_REQ: 1 = write, 0 = read, per requester.
- `req_addr`  in  NUM_REQ*ADDR_W: packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- `req_ready`  out  NUM_REQ: one-hot accept pulse; the request is latched that cycle.
- `done`  out  NUM_REQ: one-hot, one-cycle completion pulse to the granted requester.
- `cache_addr`  out  ADDR_W: address driven to the controller.
- `cache_read`  out  1: read strobe, held for the whole access.
- `cache_write`  out  1: write strobe, held for the whole access.
- `cache_ready`  in  1: controller `ready`; the access completes when this is sampled high in BUSY.
- `busy`  out  1: high while in BUSY.
- `grant_id`  out  2: index of the current or last winner.
- `timeout_err`  out  1: sticky; set when the watchdog fires, cleared only by `rst`.

## Operation
- The FSM has two states, IDLE and BUSY.
- IDLE, no `req_valid` bit set:
  - stay in IDLE;
  - all strobes are 0.
- IDLE, at least one `req_valid` bit set:
  - the winner is the first set bit searching from `last+1` upward, modulo NUM_REQ;
  - `req_ready[winner]`=1 combinationally in this cycle;
  - the winner's addr and write are latched at the next edge, `last`<=winner, `grant_id`<=winner, and the FSM goes to BUSY.
- BUSY:
  - `cache_addr` = latched address; `cache_read` = ~latched write; `cache_write` = latched write;
  - the wait counter increments every cycle;
  - `req_ready` = 0 and new requests are ignored.
- BUSY, `cache_ready` sampled high: go to IDLE, and in that following IDLE cycle `done[grant]`=1 and the counter clears.
- BUSY, counter reaches TIMEOUT-1 with no `cache_ready`: same exit as a normal completion (go to IDLE, `done[grant]` pulses), plus `timeout_err`<=1.
- Requesters may deassert `req_valid` or change `req_addr` after `req_ready`; the latched copy is used. A requester that still holds `req_valid` after its `done` is treated as a new request.
- Read and write on the same requester are not both possible: direction comes only from `req_write`.

## Timing
- Reset values:
  - state = IDLE;
  - `last` = NUM_REQ-1, so requester 0 wins first;
  - `grant_id` = NUM_REQ-1;
  - `cache_addr` = 0, `cache_read` = 0, `cache_write` = 0;
  - `req_ready` = 0, `done` = 0;
  - `busy` = 0, `timeout_err` = 0.
- Latency:
  - `req_ready` appears in the same cycle as `req_valid` if the arbiter is in IDLE;
  - strobes assert one cycle after `req_ready`;
  - `done` appears one cycle after `cache_ready`.
- Minimum access length is 2 cycles (IDLE plus one BUSY cycle). A new grant may be issued in the same IDLE cycle that carries `done`.
- Strobes are registered, glitch-free and stable for the whole BUSY interval, and deassert in the cycle `done` pulses.
- A `cache_ready` pulse while in IDLE is ignored.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0; no requester waits more than NUM_REQ-1 accesses.
- `rst` asserted mid-access:
  - return to IDLE next edge;
  - strobes drop and no `done` pulse is issued;
  - the in-flight access is abandoned and `timeout_err` clears.
- `rst` has priority over every other event in the same cycle.

## Structure
- `cache_pkg` holds:
  - `ADDR_W`;
  - the index/tag widths (7-bit index, 19-bit tag);
  - enum `arb_state_t` {ARB_IDLE, ARB_BUSY};
  - shared by `cache_controller` and this block.
- One sub-module, `rr_priority_picker`: purely combinational; inputs are the request vector and `last`; outputs are a one-hot grant and the grant index.
- The FSM, latches and watchdog counter live in the top module.

## Test plan
- Reset, then requester 0 reads 0x0000_1080:
  - `req_ready[0]` in cycle 0, `cache_read`=1 and `cache_addr`=0x0000_1080 in cycle 1;
  - with `cache_ready` at cycle 3, `done[0]` pulses at cycle 4.
- NUM_REQ=3, all requesters continuously valid, `cache_ready` 2 cycles after each strobe: grant order 0,1,2,0,1,2 and every `done` matches its `grant_id`.
- Requester 1 write to 0x0000_2000, then requester 1 drops `req_valid` and changes `req_addr` during BUSY: `cache_addr` stays 0x0000_2000 and `cache_write`=1 until completion.
- `cache_ready` never asserted, TIMEOUT=8:
  - strobes drop after 8 BUSY cycles;
  - `done` pulses and `timeout_err`=1;
  - `timeout_err` persists across later accesses until `rst`.
- `rst` pulsed during BUSY: next cycle all outputs are at reset values, no `done`, and the following grant goes to requester 0.
- Requester 0 asserts `req_valid` in the `done` cycle of a requester 1 access: `req_ready[0]` in that same cycle, with no idle gap.
